// File: rtl/imm_encoder.sv
// RISC-V immediate encoder: merges an immediate into a base instruction word,
// flags immediates that do not fit the selected format, and buffers results in a 2-deep FIFO.
module imm_encoder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            ImmSrc,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [31:0]           base_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic                  imm_err,
  output logic [15:0]           err_count
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;

  logic [DATA_WIDTH-1:0] enc_word;
  logic                  enc_err;
  logic [DATA_WIDTH-1:0] sext12;
  logic [DATA_WIDTH-1:0] sext13;
  logic [DATA_WIDTH-1:0] sext21;

  assign sext12 = {{(DATA_WIDTH-12){imm[11]}}, imm[11:0]};
  assign sext13 = {{(DATA_WIDTH-13){imm[12]}}, imm[12:0]};
  assign sext21 = {{(DATA_WIDTH-21){imm[20]}}, imm[20:0]};

  // Unused ImmSrc codes fall into the I-type branch.
  always_comb begin
    enc_word = base_instr;
    enc_err  = 1'b0;
    case (ImmSrc)
      SRC_S: begin
        enc_word[31:25] = imm[11:5];
        enc_word[11:7]  = imm[4:0];
        enc_err         = (imm != sext12);
      end
      SRC_B: begin
        enc_word[31]    = imm[12];
        enc_word[30:25] = imm[10:5];
        enc_word[11:8]  = imm[4:1];
        enc_word[7]     = imm[11];
        enc_err         = imm[0] || (imm != sext13);
      end
      SRC_U: begin
        enc_word[31:12] = imm[31:12];
        enc_err         = (imm[11:0] != 12'd0);
      end
      SRC_J: begin
        enc_word[31]    = imm[20];
        enc_word[30:21] = imm[10:1];
        enc_word[20]    = imm[11];
        enc_word[19:12] = imm[19:12];
        enc_err         = imm[0] || (imm != sext21);
      end
      default: begin
        enc_word[31:20] = imm[11:0];
        enc_err         = (imm != sext12);
      end
    endcase
  end

  logic [DATA_WIDTH-1:0] word_q [2];
  logic                  err_q  [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [1:0]            count_next;
  logic                  push;
  logic                  pop;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign instr_out = word_q[rd_ptr];
  assign imm_err   = err_q[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // in_ready is registered from the next occupancy so it never depends on out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        word_q[i] <= '0;
        err_q[i]  <= 1'b0;
      end
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      in_ready  <= 1'b0;
      err_count <= 16'd0;
    end else begin
      if (push) begin
        word_q[wr_ptr] <= enc_word;
        err_q[wr_ptr]  <= enc_err;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count    <= count_next;
      in_ready <= (count_next < 2'd2);
      if (push && enc_err && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule
